alu_issue_unit: RTL and testbench

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_wait_timer.sv | 38 +++
 rtl/alu_issue_unit.sv | 157 +++++++++++++++
 tb/tb_alu_issue_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: op codes, FSM states, defaults.
package alu_pkg;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_TIMEOUT = 64;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_NOT = 4'd2;
    localparam logic [3:0] ALU_SHL = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Codes 8..15 complete through a done flag; everything from 9 up is a divide.
    function automatic logic is_multicycle(input logic [3:0] op);
        return op >= ALU_MUL;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op >= ALU_DIV;
    endfunction

endpackage

// File: rtl/alu_wait_timer.sv
// Saturating WAIT-cycle counter; expired flags the last permitted WAIT cycle.
module alu_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // WAIT cycle k sees a count of k-1, so TIMEOUT-1 marks the final cycle.
    assign expired_o = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one request at a time to an external ALU, waits for multi-cycle
// completion with a timeout, and holds the response until it is consumed.
module alu_issue_unit #(
    parameter int DATA_W  = alu_pkg::DEFAULT_DATA_W,
    parameter int TIMEOUT = alu_pkg::DEFAULT_TIMEOUT
) (
    input  logic              inp_clk,
    input  logic              inp_rst,
    input  logic              inp_valid,
    input  logic [3:0]        inp_op,
    input  logic [DATA_W-1:0] inp_a,
    input  logic [DATA_W-1:0] inp_b,
    output logic              out_ready,
    output logic [DATA_W-1:0] out_aluData1,
    output logic [DATA_W-1:0] out_aluData2,
    output logic [3:0]        out_aluControl,
    output logic              out_start,
    input  logic [DATA_W-1:0] inp_aluResult,
    input  logic              inp_aluZero,
    input  logic              inp_mulDone,
    input  logic              inp_divDone,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_error,
    input  logic              inp_resultReady,
    output logic              out_busy
);

    import alu_pkg::*;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              error_q, error_d;

    logic accept, div_by_zero, done, expired;

    assign accept      = inp_valid && (state_q == ST_IDLE);
    assign div_by_zero = is_div(inp_op) && (inp_b == '0);
    assign done        = (ctrl_q == ALU_MUL) ? inp_mulDone : inp_divDone;

    alu_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (inp_clk),
        .rst_i     (inp_rst),
        .clear_i   (state_q == ST_LAUNCH),
        .enable_i  ((state_q == ST_WAIT) && !done),
        .expired_o (expired)
    );

    always_comb begin
        state_d  = state_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        ctrl_d   = ctrl_q;
        start_d  = 1'b0;
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data1_d = inp_a;
                    data2_d = inp_b;
                    ctrl_d  = inp_op;
                    if (div_by_zero) begin
                        state_d  = ST_RESP;
                        valid_d  = 1'b1;
                        result_d = '1;
                        zero_d   = 1'b0;
                        error_d  = 1'b1;
                    end else begin
                        state_d = ST_LAUNCH;
                        start_d = 1'b1;
                    end
                end
            end
            // Done is not looked at here: it may still reflect the previous operands.
            ST_LAUNCH: begin
                if (is_multicycle(ctrl_q)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d  = ST_RESP;
                    valid_d  = 1'b1;
                    result_d = inp_aluResult;
                    zero_d   = inp_aluZero;
                    error_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    state_d  = ST_RESP;
                    valid_d  = 1'b1;
                    result_d = inp_aluResult;
                    zero_d   = inp_aluZero;
                    error_d  = 1'b0;
                end else if (expired) begin
                    state_d  = ST_RESP;
                    valid_d  = 1'b1;
                    result_d = '1;
                    zero_d   = 1'b0;
                    error_d  = 1'b1;
                end
            end
            ST_RESP: begin
                if (inp_resultReady) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            state_q  <= ST_IDLE;
            data1_q  <= '0;
            data2_q  <= '0;
            ctrl_q   <= '0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            ctrl_q   <= ctrl_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            error_q  <= error_d;
        end
    end

    assign out_ready      = (state_q == ST_IDLE);
    assign out_busy       = (state_q != ST_IDLE);
    assign out_aluData1   = data1_q;
    assign out_aluData2   = data2_q;
    assign out_aluControl = ctrl_q;
    assign out_start      = start_q;
    assign out_valid      = valid_q;
    assign out_result     = result_q;
    assign out_zero       = zero_q;
    assign out_error      = error_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: one task per scenario, hand-computed expectations.
module tb_alu_issue_unit;

    logic        inp_clk, inp_rst, inp_valid;
    logic [3:0]  inp_op;
    logic [15:0] inp_a, inp_b, inp_aluResult;
    logic        inp_aluZero, inp_mulDone, inp_divDone, inp_resultReady;
    logic        out_ready, out_start, out_valid, out_zero, out_error, out_busy;
    logic [15:0] out_aluData1, out_aluData2, out_result;
    logic [3:0]  out_aluControl;

    int checks = 0;
    int errors = 0;

    alu_issue_unit #(.DATA_W(16), .TIMEOUT(64)) dut (
        .inp_clk         (inp_clk),
        .inp_rst         (inp_rst),
        .inp_valid       (inp_valid),
        .inp_op          (inp_op),
        .inp_a           (inp_a),
        .inp_b           (inp_b),
        .out_ready       (out_ready),
        .out_aluData1    (out_aluData1),
        .out_aluData2    (out_aluData2),
        .out_aluControl  (out_aluControl),
        .out_start       (out_start),
        .inp_aluResult   (inp_aluResult),
        .inp_aluZero     (inp_aluZero),
        .inp_mulDone     (inp_mulDone),
        .inp_divDone     (inp_divDone),
        .out_valid       (out_valid),
        .out_result      (out_result),
        .out_zero        (out_zero),
        .out_error       (out_error),
        .inp_resultReady (inp_resultReady),
        .out_busy        (out_busy)
    );

    initial begin
        inp_clk = 1'b0;
        forever #5 inp_clk = ~inp_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge inp_clk);
        #1;
    endtask

    // Present a request for exactly one accept edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        inp_valid = 1'b1; inp_op = op; inp_a = a; inp_b = b;
        tick();
        inp_valid = 1'b0;
    endtask

    task automatic ack();
        inp_resultReady = 1'b1;
        tick();
        inp_resultReady = 1'b0;
    endtask

    task automatic test_reset();
        inp_rst = 1'b1;
        tick(); tick();
        inp_rst = 1'b0;
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", out_ready); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", out_busy); end
        checks++;
        if ({out_start, out_valid, out_zero, out_error, out_result, out_aluData1, out_aluData2, out_aluControl} !== 56'd0) begin
            errors++;
            $display("FAIL reset_outputs: start %b valid %b zero %b error %b result %h d1 %h d2 %h ctrl %h want all 0",
                     out_start, out_valid, out_zero, out_error, out_result, out_aluData1, out_aluData2, out_aluControl);
        end
    endtask

    task automatic test_add();
        inp_aluResult = 16'd8; inp_aluZero = 1'b0;
        issue(4'd0, 16'd3, 16'd5);
        checks++; if (out_start !== 1'b1) begin errors++; $display("FAIL add_start: got %b want 1", out_start); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
        checks++; if ({out_aluData1, out_aluData2, out_aluControl} !== {16'd3, 16'd5, 4'd0}) begin
            errors++; $display("FAIL add_operands: got %h %h %h want 0003 0005 0", out_aluData1, out_aluData2, out_aluControl); end
        checks++; if ({out_ready, out_busy} !== 2'b01) begin errors++; $display("FAIL add_busy: ready/busy got %b want 01", {out_ready, out_busy}); end
        tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL add_start_width: got %b want 0", out_start); end
        checks++; if ({out_valid, out_result, out_zero, out_error} !== {1'b1, 16'd8, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_resp: valid %b result %h zero %b error %b want 1 0008 0 0", out_valid, out_result, out_zero, out_error); end
        ack();
        checks++; if ({out_valid, out_ready} !== 2'b01) begin errors++; $display("FAIL add_return: valid/ready got %b want 01", {out_valid, out_ready}); end
    endtask

    task automatic test_sub_hold();
        inp_aluResult = 16'd0; inp_aluZero = 1'b1;
        issue(4'd1, 16'd7, 16'd7);
        tick();
        inp_aluResult = 16'h1234; inp_aluZero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({out_valid, out_result, out_zero, out_error} !== {1'b1, 16'd0, 1'b1, 1'b0}) begin
                errors++; $display("FAIL sub_hold_%0d: valid %b result %h zero %b error %b want 1 0000 1 0", i, out_valid, out_result, out_zero, out_error); end
            checks++; if ({out_aluData1, out_aluData2, out_aluControl} !== {16'd7, 16'd7, 4'd1}) begin
                errors++; $display("FAIL sub_operands_%0d: got %h %h %h want 0007 0007 1", i, out_aluData1, out_aluData2, out_aluControl); end
            tick();
        end
        // A request presented during the response must not be taken on the ack edge.
        inp_valid = 1'b1; inp_op = 4'd0; inp_a = 16'd9; inp_b = 16'd9;
        ack();
        inp_valid = 1'b0;
        checks++; if ({out_valid, out_ready, out_busy, out_start} !== 4'b0100) begin
            errors++; $display("FAIL sub_return: valid/ready/busy/start got %b want 0100", {out_valid, out_ready, out_busy, out_start}); end
    endtask

    task automatic test_mul_stale_done();
        issue(4'd8, 16'd300, 16'd200);
        inp_mulDone = 1'b1; inp_aluResult = 16'hDEAD; inp_aluZero = 1'b0;
        tick();
        inp_mulDone = 1'b0; inp_aluResult = 16'hEA60;
        checks++; if ({out_valid, out_busy} !== 2'b01) begin errors++; $display("FAIL mul_launch_done: valid/busy got %b want 01", {out_valid, out_busy}); end
        for (int i = 1; i <= 16; i++) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_wait16: valid got %b want 0", out_valid); end
        inp_mulDone = 1'b1;
        tick();
        inp_mulDone = 1'b0;
        checks++; if ({out_valid, out_result, out_zero, out_error} !== {1'b1, 16'hEA60, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mul_resp: valid %b result %h zero %b error %b want 1 ea60 0 0", out_valid, out_result, out_zero, out_error); end
        ack();
    endtask

    task automatic test_div_by_zero();
        inp_aluResult = 16'h0055;
        issue(4'd9, 16'd100, 16'd0);
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL dz_start: got %b want 0", out_start); end
        checks++; if ({out_valid, out_result, out_zero, out_error} !== {1'b1, 16'hFFFF, 1'b0, 1'b1}) begin
            errors++; $display("FAIL dz_resp: valid %b result %h zero %b error %b want 1 ffff 0 1", out_valid, out_result, out_zero, out_error); end
        tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL dz_start_late: got %b want 0", out_start); end
        ack();
    endtask

    task automatic test_div_timeout(input logic done_at_64);
        inp_divDone = 1'b0; inp_aluResult = 16'd14; inp_aluZero = 1'b0;
        issue(4'd10, 16'd100, 16'd7);
        tick();
        for (int i = 1; i <= 63; i++) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL div_wait63_%0d: valid got %b want 0", done_at_64, out_valid); end
        inp_divDone = done_at_64;
        tick();
        inp_divDone = 1'b0;
        if (done_at_64) begin
            checks++; if ({out_valid, out_result, out_error} !== {1'b1, 16'd14, 1'b0}) begin
                errors++; $display("FAIL div_done64: valid %b result %h error %b want 1 000e 0", out_valid, out_result, out_error); end
        end else begin
            checks++; if ({out_valid, out_result, out_zero, out_error} !== {1'b1, 16'hFFFF, 1'b0, 1'b1}) begin
                errors++; $display("FAIL div_timeout: valid %b result %h zero %b error %b want 1 ffff 0 1", out_valid, out_result, out_zero, out_error); end
        end
        ack();
    endtask

    task automatic test_reset_mid_wait();
        issue(4'd8, 16'd4, 16'd4);
        tick();
        for (int i = 1; i <= 9; i++) tick();
        inp_rst = 1'b1;
        tick();
        inp_rst = 1'b0;
        checks++; if ({out_ready, out_busy, out_valid, out_start} !== 4'b1000) begin
            errors++; $display("FAIL rstwait_ctrl: ready/busy/valid/start got %b want 1000", {out_ready, out_busy, out_valid, out_start}); end
        checks++; if ({out_result, out_zero, out_error, out_aluData1, out_aluData2, out_aluControl} !== 54'd0) begin
            errors++; $display("FAIL rstwait_data: result %h d1 %h d2 %h ctrl %h want 0", out_result, out_aluData1, out_aluData2, out_aluControl); end
        inp_aluResult = 16'd2; inp_aluZero = 1'b0;
        issue(4'd0, 16'd1, 16'd1);
        tick();
        checks++; if ({out_valid, out_result, out_error} !== {1'b1, 16'd2, 1'b0}) begin
            errors++; $display("FAIL rstwait_add: valid %b result %h error %b want 1 0002 0", out_valid, out_result, out_error); end
        ack();
    endtask

    task automatic test_reset_mid_resp();
        issue(4'd12, 16'd5, 16'd0);
        inp_rst = 1'b1;
        tick();
        inp_rst = 1'b0;
        checks++; if ({out_valid, out_error, out_result, out_ready} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
            errors++; $display("FAIL rstresp: valid %b error %b result %h ready %b want 0 0 0000 1", out_valid, out_error, out_result, out_ready); end
    endtask

    initial begin
        inp_rst = 1'b1; inp_valid = 1'b0; inp_op = 4'd0; inp_a = '0; inp_b = '0;
        inp_aluResult = '0; inp_aluZero = 1'b0; inp_mulDone = 1'b0; inp_divDone = 1'b0;
        inp_resultReady = 1'b0;
        test_reset();
        test_add();
        test_sub_hold();
        test_mul_stale_done();
        test_div_by_zero();
        test_div_timeout(1'b0);
        test_div_timeout(1'b1);
        test_reset_mid_wait();
        test_reset_mid_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
